// File: rtl/lr35902_oam_dma_pkg.sv
// Shared constants, state encoding and source-page helpers for the FF46 OAM DMA engine.
// No timing of its own; used by the DMA block and its bench.
package lr35902_oam_dma_pkg;

  localparam logic [15:0] DMA_REG_ADR   = 16'hFF46;
  localparam int          OAM_LEN       = 160;
  localparam logic [7:0]  VRAM_HI_FIRST = 8'h80;
  localparam logic [7:0]  VRAM_HI_LAST  = 8'h9F;
  localparam logic [7:0]  ECHO_HI       = 8'hE0;
  localparam logic [7:0]  ECHO_OFS      = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2
  } dma_state_e;

  // Echo RAM pages alias work RAM 0x20 pages lower.
  function automatic logic [7:0] src_base(input logic [7:0] s);
    return (s >= ECHO_HI) ? (s - ECHO_OFS) : s;
  endfunction

  function automatic logic src_is_ext(input logic [7:0] base);
    return (base < VRAM_HI_FIRST) || (base > VRAM_HI_LAST);
  endfunction

endpackage

// File: rtl/lr35902_oam_dma_if.sv
// CPU register port plus source-read / OAM-write bus of the OAM DMA engine.
// slave = DMA side, master = CPU / memory side.
interface lr35902_oam_dma_if;

  logic [7:0]  reg_din;
  logic        reg_write;
  logic        reg_read;
  logic [7:0]  reg_dout;
  logic        active;
  logic        drvext;
  logic [15:0] adr_rd;
  logic        rd;
  logic [7:0]  data_in;
  logic [7:0]  adr_wr;
  logic        wr;
  logic [7:0]  data_out;

  modport slave (
    input  reg_din, reg_write, reg_read, data_in,
    output reg_dout, active, drvext, adr_rd, rd, adr_wr, wr, data_out
  );

  modport master (
    output reg_din, reg_write, reg_read, data_in,
    input  reg_dout, active, drvext, adr_rd, rd, adr_wr, wr, data_out
  );

endinterface

// File: rtl/lr35902_oam_dma.sv
// FF46 OAM DMA: copies LEN bytes from page {base} into OAM, one byte per MCYC-clock slot.
// active rises the clock after the FF46 write; no backpressure, a rewrite restarts the copy.
module lr35902_oam_dma
  import lr35902_oam_dma_pkg::*;
#(
  parameter int LEN  = OAM_LEN,
  parameter int MCYC = 4
) (
  input  logic                clk,
  input  logic                n_reset,
  lr35902_oam_dma_if.slave    bus
);

  // Slot phases 0..2 must exist, so MCYC is expected to be at least 3.
  localparam int             PW       = (MCYC > 1) ? $clog2(MCYC) : 1;
  localparam logic [PW-1:0]  PH_LAST  = PW'(MCYC - 1);
  localparam logic [PW-1:0]  PH_RD1   = PW'(1);
  localparam logic [PW-1:0]  PH_WR    = PW'(2);
  localparam logic [7:0]     IDX_LAST = 8'(LEN - 1);

  dma_state_e     state_q,    state_d;
  logic [PW-1:0]  phase_q,    phase_d;
  logic [7:0]     idx_q,      idx_d;
  logic [7:0]     s_q,        s_d;
  logic [15:0]    adr_rd_q,   adr_rd_d;
  logic [7:0]     adr_wr_q,   adr_wr_d;
  logic [7:0]     data_out_q, data_out_d;

  logic [7:0]     base;
  logic           in_xfer;
  logic           unused_reg_read;

  assign base            = src_base(s_q);
  assign in_xfer         = (state_q == ST_XFER);
  assign unused_reg_read = bus.reg_read;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      idx_q      <= 8'h00;
      s_q        <= 8'hFF;
      adr_rd_q   <= 16'h0000;
      adr_wr_q   <= 8'h00;
      data_out_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      s_q        <= s_d;
      adr_rd_q   <= adr_rd_d;
      adr_wr_q   <= adr_wr_d;
      data_out_q <= data_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    s_d        = s_q;
    adr_rd_d   = adr_rd_q;
    adr_wr_d   = adr_wr_q;
    data_out_d = data_out_q;

    case (state_q)
      ST_START: begin
        if (phase_q == PH_LAST) begin
          state_d  = ST_XFER;
          phase_d  = '0;
          idx_d    = 8'h00;
          adr_rd_d = {base, 8'h00};
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_XFER: begin
        // Source data arrives one clock after rd; capture it with the index it belongs to.
        if (phase_q == PH_RD1) begin
          data_out_d = bus.data_in;
          adr_wr_d   = idx_q;
        end
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_IDLE;
          end else begin
            idx_d    = idx_q + 8'd1;
            adr_rd_d = {base, idx_q + 8'd1};
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
      end
    endcase

    // A register write always (re)starts the transfer; rd/wr of the current clock are unaffected.
    if (bus.reg_write) begin
      s_d     = bus.reg_din;
      state_d = ST_START;
      phase_d = '0;
      idx_d   = 8'h00;
    end
  end

  assign bus.reg_dout = s_q;
  assign bus.active   = (state_q != ST_IDLE);
  assign bus.drvext   = (state_q != ST_IDLE) && src_is_ext(base);
  assign bus.rd       = in_xfer && (phase_q <= PH_RD1);
  assign bus.wr       = in_xfer && (phase_q == PH_WR);
  assign bus.adr_rd   = adr_rd_q;
  assign bus.adr_wr   = adr_wr_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_lr35902_oam_dma.sv
// Randomised scoreboard bench for the FF46 OAM DMA: expected reads/writes queued at each FF46 write,
// a negedge monitor pops and compares every rd/wr and tracks active/drvext against a clock budget.
module tb_lr35902_oam_dma;
  import lr35902_oam_dma_pkg::*;

  localparam int LEN      = OAM_LEN;
  localparam int MCYC     = 4;
  localparam int ACT_CLKS = MCYC * (LEN + 1);

  logic clk     = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  lr35902_oam_dma_if bus();

  lr35902_oam_dma #(.LEN(LEN), .MCYC(MCYC)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  typedef struct packed {
    logic [7:0] idx;
    logic [7:0] dat;
  } wexp_t;

  wexp_t       wq[$];
  logic [15:0] rq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          act_left = 0;
  logic [7:0]  exp_base = 8'hFF;
  bit          mon_en = 1'b0;
  bit          prev_active = 1'b0;
  int          t_write = 0;
  int          first_rd = -1;
  int          second_rd = -1;
  int          first_wr = -1;
  int          fall_at = -1;
  int          wr_count = 0;

  function automatic logic [7:0] map_base(input logic [7:0] s);
    return (s >= 8'hE0) ? (s - 8'h20) : s;
  endfunction

  // Page 0x00 yields idx ^ 0x5A; other pages are scrambled so the page is checked through the data too.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    logic [7:0] hi_mix;
    hi_mix = 8'(a[15:8] * 8'd37);
    return a[7:0] ^ 8'h5A ^ hi_mix;
  endfunction

  function automatic bit ext_drive(input logic [7:0] b);
    return (b < 8'h80) || (b >= 8'hA0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Source memory with one clock of read latency.
  always @(posedge clk) if (bus.rd) bus.data_in <= src_byte(bus.adr_rd);

  always @(negedge clk) begin
    int          lbl;
    logic [31:0] ex;
    wexp_t       e;
    if (mon_en) begin
      lbl = cyc + 1;
      check("active", 32'(bus.active), 32'(act_left > 0));
      check("drvext", 32'(bus.drvext), 32'((act_left > 0) && ext_drive(exp_base)));
      check("rd_wr_overlap", 32'(bus.rd & bus.wr), 32'h0);
      if (bus.rd) begin
        if (first_rd < 0) first_rd = lbl;
        else if (second_rd < 0) second_rd = lbl;
        if (rq.size() > 0) ex = 32'(rq.pop_front());
        else ex = 32'h0001_0000;
        check("rd_adr", 32'(bus.adr_rd), ex);
      end
      if (bus.wr) begin
        if (first_wr < 0) first_wr = lbl;
        wr_count++;
        if (wq.size() > 0) begin
          e  = wq.pop_front();
          ex = {16'h0, e};
        end else begin
          ex = 32'h0001_0000;
        end
        check("wr_idx_data", {16'h0, bus.adr_wr, bus.data_out}, ex);
      end
      if (prev_active && !bus.active && fall_at < 0) fall_at = lbl;
      prev_active = bus.active;
      if (act_left > 0) act_left--;
    end
  end

  task automatic write_reg(input logic [7:0] v);
    logic [15:0] a;
    @(negedge clk); #1;
    bus.reg_din   = v;
    bus.reg_write = 1'b1;
    bus.reg_read  = 1'($urandom_range(0, 1));
    t_write   = cyc + 1;
    first_rd  = -1;
    second_rd = -1;
    first_wr  = -1;
    fall_at   = -1;
    wr_count  = 0;
    exp_base  = map_base(v);
    act_left  = ACT_CLKS;
    wq.delete();
    rq.delete();
    for (int i = 0; i < LEN; i++) begin
      a = {exp_base, 8'(i)};
      rq.push_back(a);
      rq.push_back(a);
      wq.push_back('{idx: 8'(i), dat: src_byte(a)});
    end
    @(negedge clk); #1;
    bus.reg_write = 1'b0;
    bus.reg_din   = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((act_left > 0 || wq.size() > 0) && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    check("idle_timeout", 32'(n < 3000), 32'h1);
    repeat (2) begin
      @(negedge clk); #1;
    end
    check("wr_leftover", 32'(wq.size()), 32'h0);
  endtask

  task automatic wait_wr(input int target);
    int n;
    n = 0;
    while (wr_count < target && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check("wr_wait_timeout", 32'(n < 2000), 32'h1);
  endtask

  task automatic post_check(input logic [7:0] v);
    check("reg_dout", 32'(bus.reg_dout), 32'(v));
    check("wr_count", 32'(wr_count), 32'(LEN));
    check("active_span", 32'(fall_at - t_write), 32'(ACT_CLKS + 1));
    check("hold_adr_rd", 32'(bus.adr_rd), 32'({exp_base, 8'(LEN - 1)}));
    check("hold_adr_wr", 32'(bus.adr_wr), 32'(LEN - 1));
    check("hold_data_out", 32'(bus.data_out), 32'(src_byte({exp_base, 8'(LEN - 1)})));
  endtask

  initial begin
    logic [7:0] v;
    bus.reg_din   = 8'h00;
    bus.reg_write = 1'b0;
    bus.reg_read  = 1'b0;
    n_reset       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_active",   32'(bus.active),   32'h0);
    check("rst_drvext",   32'(bus.drvext),   32'h0);
    check("rst_rd",       32'(bus.rd),       32'h0);
    check("rst_wr",       32'(bus.wr),       32'h0);
    check("rst_adr_rd",   32'(bus.adr_rd),   32'h0);
    check("rst_adr_wr",   32'(bus.adr_wr),   32'h0);
    check("rst_data_out", 32'(bus.data_out), 32'h0);
    check("rst_reg_dout", 32'(bus.reg_dout), 32'hFF);
    #1;
    n_reset = 1'b1;
    mon_en  = 1'b1;

    // Work RAM source: exact slot timing.
    write_reg(8'hC1);
    wait_idle();
    check("first_rd_time",  32'(first_rd - t_write),  32'd5);
    check("second_rd_time", 32'(second_rd - t_write), 32'd6);
    check("first_wr_time",  32'(first_wr - t_write),  32'd7);
    post_check(8'hC1);

    // VRAM source keeps the external pins released; page 0 exercises the idx ^ 0x5A pattern.
    write_reg(8'h80);
    wait_idle();
    post_check(8'h80);
    write_reg(8'h00);
    wait_idle();
    post_check(8'h00);

    // Echo RAM maps to 0xDExx while FF46 reads back the written value.
    write_reg(8'hFE);
    wait_idle();
    post_check(8'hFE);

    // Rewrite during byte 50 restarts the copy from index 0 without dropping active.
    write_reg(8'hC3);
    wait_wr(50);
    repeat (2) @(negedge clk);
    write_reg(8'hD0);
    wait_idle();
    check("restart_first_rd", 32'(first_rd - t_write), 32'd5);
    post_check(8'hD0);

    // Reset during byte 80 aborts and nothing is written afterwards.
    write_reg(8'h3C);
    wait_wr(80);
    @(negedge clk); #1;
    n_reset  = 1'b0;
    act_left = 0;
    wq.delete();
    rq.delete();
    wr_count = 0;
    @(negedge clk); #1;
    check("abort_active",   32'(bus.active),   32'h0);
    check("abort_wr",       32'(bus.wr),       32'h0);
    check("abort_reg_dout", 32'(bus.reg_dout), 32'hFF);
    check("abort_adr_rd",   32'(bus.adr_rd),   32'h0);
    n_reset = 1'b1;
    repeat (700) @(negedge clk);
    #1;
    check("wr_after_reset", 32'(wr_count), 32'h0);

    // Reset wins over a register write on the same edge.
    @(negedge clk); #1;
    n_reset       = 1'b0;
    bus.reg_write = 1'b1;
    bus.reg_din   = 8'h11;
    @(negedge clk); #1;
    check("prio_active",   32'(bus.active),   32'h0);
    check("prio_reg_dout", 32'(bus.reg_dout), 32'hFF);
    n_reset       = 1'b1;
    bus.reg_write = 1'b0;
    repeat (3) @(negedge clk);
    #1;

    // Random sources, sometimes rewritten mid-transfer.
    for (int k = 0; k < 4; k++) begin
      v = 8'($urandom);
      write_reg(v);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(10, 600)) @(negedge clk);
        v = 8'($urandom);
        write_reg(v);
      end
      wait_idle();
      post_check(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lr35902_oam_dma.md
LR35902_OAM_DMA -- requirements
Module: lr35902_oam_dma

Interface
REQ-001 SHALL have parameter LEN, default 160, meaning the number of bytes copied per transfer.
REQ-002 SHALL have parameter MCYC, default 4, meaning the clocks per byte slot and the clocks in the start delay.
REQ-003 SHALL have port clk, input, 1 bit: the single clock (gbclk domain); all logic is on the rising edge.
REQ-004 SHALL have port n_reset, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port reg_din, input, 8 bits: CPU write data for register FF46.
REQ-006 SHALL have port reg_write, input, 1 bit: FF46 write strobe, sampled on each rising edge.
REQ-007 SHALL have port reg_read, input, 1 bit: FF46 read strobe.
REQ-008 SHALL have port reg_dout, output, 8 bits: FF46 readback.
REQ-009 SHALL have port active, output, 1 bit: DMA owns the OAM port.
REQ-010 SHALL have port drvext, output, 1 bit: DMA drives the external address and n_read pins.
REQ-011 SHALL have port adr_rd, output, 16 bits: source address.
REQ-012 SHALL have port rd, output, 1 bit: source read strobe.
REQ-013 SHALL have port data_in, input, 8 bits: source read data.
REQ-014 SHALL have port adr_wr, output, 8 bits: OAM destination index.
REQ-015 SHALL have port wr, output, 1 bit: OAM write strobe.
REQ-016 SHALL have port data_out, output, 8 bits: OAM write data.

Function
REQ-017 The FF46 write SHALL latch reg_din as register value S; reg_dout always returns S (S resets to 0xFF); reg_read has no side effect.
REQ-018 Source base high byte SHALL be S, except S >= 0xE0, which maps to S-0x20 (echo RAM); adr_rd = {base, idx}.
REQ-019 States SHALL be IDLE, START and XFER; a write seen at edge T SHALL make active=1 from T+1 and enter START for MCYC clocks with rd=wr=0.
REQ-020 XFER SHALL use byte slots of MCYC clocks for idx = 0..LEN-1; slot n begins at clock T+1+MCYC*(n+1).
REQ-021 Within a slot, phases 0-1 SHALL drive rd=1, and data_in SHALL be captured at the edge ending phase 1 (one-clock source read latency).
REQ-022 Phase 2 SHALL drive wr=1, adr_wr=idx and data_out=captured byte; phase 3 SHALL be idle.
REQ-023 After the last slot's phase 3 the block SHALL return to IDLE and set active=0; for LEN=160 and MCYC=4, active is high for exactly 644 clocks.
REQ-024 drvext SHALL be active AND (base < 0x80 OR base >= 0xA0); it is 0 for VRAM sources.
REQ-025 An FF46 write while active SHALL update S, restart at START with idx=0 and keep active high continuously; a wr already in progress for that clock still completes.
REQ-026 Outside phases 0-1 rd SHALL be 0; outside phase 2 wr SHALL be 0; adr_rd, adr_wr and data_out SHALL hold their last values when idle.
REQ-027 idx SHALL be 8 bits and never exceed LEN-1; the source address SHALL never cross out of page {base}.

Reset
REQ-028 When n_reset=0 at an edge, the block SHALL enter IDLE and set active=0, drvext=0, rd=0, wr=0, adr_rd=0, adr_wr=0, data_out=0 and S=0xFF.
REQ-029 Reset SHALL abort a transfer mid-operation with no further wr, and reset SHALL take priority over a simultaneous reg_write.

Structure
REQ-030 A shared package SHALL hold the constants DMA_REG_ADR=0xFF46, OAM_LEN=160, VRAM_HI_FIRST=0x80, VRAM_HI_LAST=0x9F and ECHO_HI=0xE0, plus the state enum.
REQ-031 The block SHALL be one flat module; no sub-module is needed (phase counter, index counter and FSM are inline).

Verification
REQ-032 Bench SHALL cover: write 0xC1 at T -> active from T+1; rd at T+5/T+6 with adr_rd=0xC100; wr at T+7 with adr_wr=0; 160 wr pulses with adr_wr 0..159; last adr_rd=0xC19F; active falls at T+645.
REQ-033 Bench SHALL cover: source 0x80 -> drvext=0 throughout and active=1; source 0x00 -> drvext=1 for the whole transfer.
REQ-034 Bench SHALL cover: source 0xFE -> adr_rd runs 0xDE00..0xDE9F and reg_dout=0xFE.
REQ-035 Bench SHALL cover: rewrite 0xD0 during byte 50 -> active stays 1, START restarts, next rd has adr_rd=0xD000 and the next wr has adr_wr=0, and 160 further wr pulses follow.
REQ-036 Bench SHALL cover: n_reset=0 during byte 80 -> the next clock shows active=0, wr=0 and reg_dout=0xFF, with no wr after release until a new write.
REQ-037 Bench SHALL cover: a data_in pattern of idx XOR 0x5A -> each wr carries data_out equal to that pattern for its adr_wr.
